// File: rtl/crypto_exec_if.sv
// Issue-side operand bus and register-file writeback port of the crypto execute unit.
interface crypto_exec_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [REG_AW-1:0] in_dest;
    logic              flush;
    logic              busy;
    logic              wb_enable;
    logic [REG_AW-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;

    // Issue stage / register file side
    modport master (
        output in_valid, in_op, in_a, in_b, in_dest, flush,
        input  in_ready, busy, wb_enable, wb_reg, wb_data
    );

    // Execute unit side
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_dest, flush,
        output in_ready, busy, wb_enable, wb_reg, wb_data
    );
endinterface

// File: rtl/crypto_exec_unit.sv
// Execute stage: single-cycle ALU/crypto ops plus a 32-cycle shift-add multiply,
// producing a registered writeback triple for the register file.
module crypto_exec_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input logic          clk,
    input logic          rst_n,
    crypto_exec_if.slave bus
);
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_ROTL  = 3'd4;
    localparam logic [2:0] OP_ROTR  = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;
    localparam logic [2:0] OP_BSWAP = 3'd7;

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] mcand, mcand_d;
    logic [DATA_W-1:0] mplier, mplier_d;
    logic [DATA_W-1:0] acc, acc_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [REG_AW-1:0] dest, dest_d;
    logic              wb_enable_d;
    logic [REG_AW-1:0] wb_reg_d;
    logic [DATA_W-1:0] wb_data_d;

    logic              accept;
    logic              mul_last;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] acc_sum;
    logic [2*DATA_W-1:0] rotl_wide, rotr_wide;

    // Handshake: ready whenever no multiply runs and no flush blocks the slot
    assign bus.in_ready = (state == IDLE) && !bus.flush;
    assign bus.busy     = (state == MUL);
    assign accept       = bus.in_valid && bus.in_ready;
    assign mul_last     = (cnt == CNT_W'(31));
    assign acc_sum      = acc + (mplier[0] ? mcand : '0);

    // Single-cycle result; rotates via a doubled operand so amount 0 needs no special case
    always_comb begin
        rotl_wide = {bus.in_a, bus.in_a} << bus.in_b[4:0];
        rotr_wide = {bus.in_a, bus.in_a} >> bus.in_b[4:0];
        alu_res   = '0;
        case (bus.in_op)
            OP_ADD:   alu_res = bus.in_a + bus.in_b;
            OP_SUB:   alu_res = bus.in_a - bus.in_b;
            OP_XOR:   alu_res = bus.in_a ^ bus.in_b;
            OP_AND:   alu_res = bus.in_a & bus.in_b;
            OP_ROTL:  alu_res = rotl_wide[2*DATA_W-1:DATA_W];
            OP_ROTR:  alu_res = rotr_wide[DATA_W-1:0];
            OP_BSWAP: alu_res = {bus.in_a[7:0], bus.in_a[15:8],
                                 bus.in_a[23:16], bus.in_a[31:24]};
            default:  alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state: enter MUL on a multiply accept, leave on flush or the 32nd step
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept && (bus.in_op == OP_MUL)) state_d = MUL;
            MUL:  if (bus.flush || mul_last)           state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; writeback strobe defaults low, data/reg hold
    always_comb begin
        wb_enable_d = 1'b0;
        wb_reg_d    = bus.wb_reg;
        wb_data_d   = bus.wb_data;
        mcand_d     = mcand;
        mplier_d    = mplier;
        acc_d       = acc;
        cnt_d       = cnt;
        dest_d      = dest;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.in_op == OP_MUL) begin
                        mcand_d  = bus.in_a;
                        mplier_d = bus.in_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        dest_d   = bus.in_dest;
                    end else begin
                        wb_enable_d = (bus.in_dest != '0);
                        wb_reg_d    = bus.in_dest;
                        wb_data_d   = alu_res;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand << 1;
                mplier_d = mplier >> 1;
                cnt_d    = CNT_W'(cnt + CNT_W'(1));
                if (!bus.flush && mul_last) begin
                    wb_enable_d = (dest != '0);
                    wb_reg_d    = dest;
                    wb_data_d   = acc_sum;
                end
            end
            default: ;
        endcase
    end

    // Datapath and writeback registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            cnt           <= '0;
            dest          <= '0;
            bus.wb_enable <= 1'b0;
            bus.wb_reg    <= '0;
            bus.wb_data   <= '0;
        end else begin
            mcand         <= mcand_d;
            mplier        <= mplier_d;
            acc           <= acc_d;
            cnt           <= cnt_d;
            dest          <= dest_d;
            bus.wb_enable <= wb_enable_d;
            bus.wb_reg    <= wb_reg_d;
            bus.wb_data   <= wb_data_d;
        end
    end
endmodule

// File: tb/tb_crypto_exec_unit.sv
// Scoreboard bench for crypto_exec_unit: stimulus pushes expected writebacks, monitor pops and compares.
module tb_crypto_exec_unit;
    logic clk = 1'b0;
    logic rst_n;

    crypto_exec_if bus ();

    crypto_exec_unit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every writeback strobe must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.wb_enable === 1'b1) begin
            wb_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb actual reg=%0d data=0x%08h required=none",
                         bus.wb_reg, bus.wb_data);
            end else begin
                e = exp_q.pop_front();
                check("wb_reg", 32'(bus.wb_reg), 32'(e.r));
                check("wb_data", bus.wb_data, e.d);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
    endtask

    // Present one op for one accepting edge; returns #1 after that edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest, input logic [31:0] exp);
        wb_t e;
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_dest  = dest;
        if (dest != 5'd0) begin
            e.r = dest;
            e.d = exp;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = 3'd0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_dest  = '0;
        bus.flush    = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_wb_enable", 32'(bus.wb_enable), 32'd0);
        check("rst_wb_reg", 32'(bus.wb_reg), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        #22;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back single-cycle ops
        issue(3'd0, 32'h0000_0005, 32'h0000_0003, 5'd4, 32'h0000_0008);
        issue(3'd1, 32'h0000_0000, 32'h0000_0001, 5'd5, 32'hFFFF_FFFF);
        issue(3'd4, 32'h8000_0001, 32'd1,         5'd6, 32'h0000_0003);
        issue(3'd5, 32'h0000_00F1, 32'd36,        5'd8, 32'h1000_000F);
        issue(3'd7, 32'h1122_3344, 32'hFFFF_FFFF, 5'd9, 32'h4433_2211);
        issue(3'd3, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd10, 32'h00F0_F000);
        issue(3'd4, 32'h1234_5678, 32'd0,         5'd11, 32'h1234_5678);
        idle_cycles(1);
        check("wb_drops_when_idle", 32'(bus.wb_enable), 32'd0);

        // r0 suppression: data still updates, strobe stays low
        issue(3'd2, 32'hDEAD_BEEF, 32'h0000_0000, 5'd0, 32'h0);
        @(negedge clk);
        check("r0_wb_enable", 32'(bus.wb_enable), 32'd0);
        check("r0_wb_data", bus.wb_data, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // MUL with in_valid held high during busy: fixed 32-cycle latency
        issue(3'd6, 32'h0001_0001, 32'h0001_0001, 5'd7, 32'h0002_0001);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd0;
        bus.in_a     = 32'd1;
        bus.in_b     = 32'd1;
        bus.in_dest  = 5'd12;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.wb_enable !== 1'b0) begin
                check("mul_busy_window", {29'd0, bus.busy, bus.in_ready, bus.wb_enable}, 32'b100);
            end else begin
                checks++;
            end
        end
        @(negedge clk);
        check("mul_done_busy", 32'(bus.busy), 32'd0);
        check("mul_done_ready", 32'(bus.in_ready), 32'd1);
        check("mul_done_strobe", 32'(bus.wb_enable), 32'd1);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("mul_strobe_once", 32'(bus.wb_enable), 32'd0);

        issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0000_0001);
        issue(3'd6, 32'h0000_1234, 32'h0000_0000, 5'd14, 32'h0000_0000);
        issue(3'd0, 32'h0000_0010, 32'h0000_0020, 5'd15, 32'h0000_0030);

        // Flush in IDLE blocks accept
        bus.flush = 1'b1;
        #1;
        check("flush_idle_ready", 32'(bus.in_ready), 32'd0);
        idle_cycles(1);
        bus.flush = 1'b0;

        // Flush on the 10th busy cycle
        issue(3'd6, 32'h0000_0003, 32'h0000_0005, 5'd16, 32'h0);
        void'(exp_q.pop_back());
        idle_cycles(9);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush10_busy", 32'(bus.busy), 32'd0);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
        end

        // Flush on the 32nd busy cycle: no writeback
        issue(3'd6, 32'h0000_0003, 32'h0000_0005, 5'd17, 32'h0);
        void'(exp_q.pop_back());
        idle_cycles(31);
        check("flush32_still_busy", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush32_busy", 32'(bus.busy), 32'd0);
        check("flush32_no_wb", 32'(bus.wb_enable), 32'd0);
        idle_cycles(3);

        // Asynchronous reset mid-multiply
        issue(3'd6, 32'h0000_0007, 32'h0000_0009, 5'd18, 32'h0);
        void'(exp_q.pop_back());
        idle_cycles(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_wb_enable", 32'(bus.wb_enable), 32'd0);
        check("arst_wb_data", bus.wb_data, 32'd0);
        #10;
        rst_n = 1'b1;
        #1;
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        issue(3'd0, 32'h0000_0100, 32'h0000_0023, 5'd19, 32'h0000_0123);
        idle_cycles(40);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expected actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
